// File: rtl/mem_controller_rr.sv
// -----------------------------------------------------------------------------
// mem_controller_rr
//
// Round-robin memory controller. Arbitrates NUM_CONSUMERS read/write requesters
// onto NUM_CHANNELS independent memory channels. Each channel runs its own small
// FSM. A shared claimed mask stops two channels from serving the same consumer.
// A shared rr_ptr rotates the scan start point so that no consumer starves.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   consumer_read_valid/address  per-consumer read request (packed addresses)
//   consumer_read_ready/data     per-consumer read completion and read data
//   consumer_write_valid/address/data  per-consumer write request
//   consumer_write_ready         per-consumer write completion
//   mem_read_valid/address       per-channel read request to memory
//   mem_read_ready/data          per-channel read response from memory
//   mem_write_valid/address/data per-channel write request to memory
//   mem_write_ready              per-channel write acknowledge from memory
//   timeout_flag                 sticky per-channel timeout indicator
//
// Optional feature
//   MEM_TIMEOUT_EN : when defined, a channel that waits TIMEOUT_CYCLES cycles
//   for memory gives up. It completes to the consumer, and a timed-out read
//   returns all-ones. When undefined, channels wait forever and timeout_flag
//   is tied to 0.
// -----------------------------------------------------------------------------
module mem_controller_rr #(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 16,
    parameter int NUM_CONSUMERS  = 4,
    parameter int NUM_CHANNELS   = 2,
    parameter int WRITE_ENABLE   = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_CONSUMERS-1:0]            consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]            consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]            consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]            consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]             mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]   mem_read_address,
    input  logic [NUM_CHANNELS-1:0]             mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]   mem_read_data,
    output logic [NUM_CHANNELS-1:0]             mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]   mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]   mem_write_data,
    input  logic [NUM_CHANNELS-1:0]             mem_write_ready,
    output logic [NUM_CHANNELS-1:0]             timeout_flag
);

    localparam int CIDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_READ_WAIT   = 3'd1;
    localparam logic [2:0] ST_WRITE_WAIT  = 3'd2;
    localparam logic [2:0] ST_READ_RELAY  = 3'd3;
    localparam logic [2:0] ST_WRITE_RELAY = 3'd4;

    logic [2:0]               state [NUM_CHANNELS];
    logic [CIDX_W-1:0]        owner [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  cancelled;
    logic [NUM_CONSUMERS-1:0] claimed;
    logic [CIDX_W-1:0]        rr_ptr;

    logic [NUM_CHANNELS-1:0]  grant_valid;
    logic [NUM_CHANNELS-1:0]  grant_read;
    logic [CIDX_W-1:0]        grant_idx [NUM_CHANNELS];
    logic                     any_grant;
    logic [CIDX_W-1:0]        rr_next;
    logic [NUM_CONSUMERS-1:0] write_req;

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt [NUM_CHANNELS];
`else
    assign timeout_flag = '0;
`endif

    // With the write path removed, write requests never become grant
    // candidates, so the write outputs keep their reset value of 0.
    assign write_req = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;

    // Arbitration: idle channels pick consumers in ascending channel order.
    // The taken mask grows as each channel grants. This lets a lower
    // channel's pick hide that consumer from the higher channels in the same
    // cycle.
    always_comb begin
        logic [NUM_CONSUMERS-1:0] taken;
        logic [CIDX_W-1:0]        cand;
        logic [CIDX_W-1:0]        last;
        logic                     found;
        int                       sum;
        taken       = claimed;
        cand        = '0;
        last        = '0;
        found       = 1'b0;
        sum         = 0;
        grant_valid = '0;
        grant_read  = '0;
        any_grant   = 1'b0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            grant_idx[ch] = '0;
        end
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            found = 1'b0;
            if (state[ch] == ST_IDLE) begin
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    sum = int'(rr_ptr) + k;
                    if (sum >= NUM_CONSUMERS) begin
                        sum = sum - NUM_CONSUMERS;
                    end
                    cand = CIDX_W'(sum);
                    if (!found && !taken[cand] &&
                        (consumer_read_valid[cand] || write_req[cand])) begin
                        found           = 1'b1;
                        grant_valid[ch] = 1'b1;
                        grant_read[ch]  = consumer_read_valid[cand];
                        grant_idx[ch]   = cand;
                        taken[cand]     = 1'b1;
                        any_grant       = 1'b1;
                        last            = cand;
                    end
                end
            end
        end
        if (int'(last) == NUM_CONSUMERS - 1) begin
            rr_next = '0;
        end else begin
            rr_next = last + 1'b1;
        end
    end

    // Channel FSMs. A consumer that drops valid while its channel is waiting
    // marks that channel cancelled. The memory access still completes, but
    // the response goes nowhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state[ch] <= ST_IDLE;
                owner[ch] <= '0;
`ifdef MEM_TIMEOUT_EN
                wait_cnt[ch] <= '0;
`endif
            end
            cancelled            <= '0;
            claimed              <= '0;
            rr_ptr               <= '0;
            mem_read_valid       <= '0;
            mem_read_address     <= '0;
            mem_write_valid      <= '0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
            consumer_read_ready  <= '0;
            consumer_read_data   <= '0;
            consumer_write_ready <= '0;
`ifdef MEM_TIMEOUT_EN
            timeout_flag         <= '0;
`endif
        end else begin
            if (any_grant) begin
                rr_ptr <= rr_next;
            end
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                case (state[ch])
                    ST_IDLE: begin
                        if (grant_valid[ch]) begin
                            owner[ch]               <= grant_idx[ch];
                            cancelled[ch]           <= 1'b0;
                            claimed[grant_idx[ch]]  <= 1'b1;
`ifdef MEM_TIMEOUT_EN
                            wait_cnt[ch]            <= '0;
`endif
                            if (grant_read[ch]) begin
                                mem_read_valid[ch] <= 1'b1;
                                mem_read_address[ch*ADDR_BITS +: ADDR_BITS] <=
                                    consumer_read_address[grant_idx[ch]*ADDR_BITS +: ADDR_BITS];
                                state[ch] <= ST_READ_WAIT;
                            end else begin
                                mem_write_valid[ch] <= 1'b1;
                                mem_write_address[ch*ADDR_BITS +: ADDR_BITS] <=
                                    consumer_write_address[grant_idx[ch]*ADDR_BITS +: ADDR_BITS];
                                mem_write_data[ch*DATA_BITS +: DATA_BITS] <=
                                    consumer_write_data[grant_idx[ch]*DATA_BITS +: DATA_BITS];
                                state[ch] <= ST_WRITE_WAIT;
                            end
                        end
                    end
                    ST_READ_WAIT: begin
                        if (mem_read_ready[ch]) begin
                            mem_read_valid[ch] <= 1'b0;
                            if (cancelled[ch] || !consumer_read_valid[owner[ch]]) begin
                                claimed[owner[ch]] <= 1'b0;
                                state[ch]          <= ST_IDLE;
                            end else begin
                                consumer_read_data[owner[ch]*DATA_BITS +: DATA_BITS] <=
                                    mem_read_data[ch*DATA_BITS +: DATA_BITS];
                                consumer_read_ready[owner[ch]] <= 1'b1;
                                state[ch]                      <= ST_READ_RELAY;
                            end
                        end else begin
                            if (!consumer_read_valid[owner[ch]]) begin
                                cancelled[ch] <= 1'b1;
                            end
`ifdef MEM_TIMEOUT_EN
                            if (wait_cnt[ch] == TW'(TIMEOUT_CYCLES - 1)) begin
                                mem_read_valid[ch] <= 1'b0;
                                timeout_flag[ch]   <= 1'b1;
                                if (cancelled[ch] || !consumer_read_valid[owner[ch]]) begin
                                    claimed[owner[ch]] <= 1'b0;
                                    state[ch]          <= ST_IDLE;
                                end else begin
                                    consumer_read_data[owner[ch]*DATA_BITS +: DATA_BITS] <= '1;
                                    consumer_read_ready[owner[ch]] <= 1'b1;
                                    state[ch]                      <= ST_READ_RELAY;
                                end
                            end else begin
                                wait_cnt[ch] <= wait_cnt[ch] + 1'b1;
                            end
`endif
                        end
                    end
                    ST_WRITE_WAIT: begin
                        if (mem_write_ready[ch]) begin
                            mem_write_valid[ch] <= 1'b0;
                            if (cancelled[ch] || !consumer_write_valid[owner[ch]]) begin
                                claimed[owner[ch]] <= 1'b0;
                                state[ch]          <= ST_IDLE;
                            end else begin
                                consumer_write_ready[owner[ch]] <= 1'b1;
                                state[ch]                       <= ST_WRITE_RELAY;
                            end
                        end else begin
                            if (!consumer_write_valid[owner[ch]]) begin
                                cancelled[ch] <= 1'b1;
                            end
`ifdef MEM_TIMEOUT_EN
                            if (wait_cnt[ch] == TW'(TIMEOUT_CYCLES - 1)) begin
                                mem_write_valid[ch] <= 1'b0;
                                timeout_flag[ch]    <= 1'b1;
                                if (cancelled[ch] || !consumer_write_valid[owner[ch]]) begin
                                    claimed[owner[ch]] <= 1'b0;
                                    state[ch]          <= ST_IDLE;
                                end else begin
                                    consumer_write_ready[owner[ch]] <= 1'b1;
                                    state[ch]                       <= ST_WRITE_RELAY;
                                end
                            end else begin
                                wait_cnt[ch] <= wait_cnt[ch] + 1'b1;
                            end
`endif
                        end
                    end
                    // Ready is held until the consumer releases valid. The
                    // claim is dropped on that same edge, so the consumer can
                    // win arbitration again on the next cycle.
                    ST_READ_RELAY: begin
                        if (!consumer_read_valid[owner[ch]]) begin
                            consumer_read_ready[owner[ch]] <= 1'b0;
                            claimed[owner[ch]]             <= 1'b0;
                            state[ch]                      <= ST_IDLE;
                        end
                    end
                    ST_WRITE_RELAY: begin
                        if (!consumer_write_valid[owner[ch]]) begin
                            consumer_write_ready[owner[ch]] <= 1'b0;
                            claimed[owner[ch]]              <= 1'b0;
                            state[ch]                       <= ST_IDLE;
                        end
                    end
                    default: begin
                        state[ch] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_controller_rr.sv
// -----------------------------------------------------------------------------
// tb_mem_controller_rr
//
// Bench for mem_controller_rr. Instance dut_a uses the default configuration
// (4 consumers, 2 channels). Instance dut_b has a single channel and is used
// for the fairness sequence. Both instances share the consumer-side inputs and
// the reset, and each has its own memory side.
// Build with MEM_TIMEOUT_EN to add the timeout sequence.
// -----------------------------------------------------------------------------
module tb_mem_controller_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [3:0]  c_rv;
    logic [3:0]  c_wv;
    logic [31:0] c_raddr;
    logic [31:0] c_waddr;
    logic [63:0] c_wdata;

    logic [3:0]  a_crr, a_cwr;
    logic [63:0] a_crd;
    logic [1:0]  a_mrv, a_mrr, a_mwv, a_mwr, a_tf;
    logic [15:0] a_mra, a_mwa;
    logic [31:0] a_mrd, a_mwd;

    logic [3:0]  b_crr, b_cwr;
    logic [63:0] b_crd;
    logic        b_mrv, b_mrr, b_mwv, b_mwr, b_tf;
    logic [7:0]  b_mra, b_mwa;
    logic [15:0] b_mrd, b_mwd;

    int n_compared   = 0;
    int n_mismatched = 0;

    mem_controller_rr #(.NUM_CHANNELS(2)) dut_a (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (c_rv),
        .consumer_read_address  (c_raddr),
        .consumer_read_ready    (a_crr),
        .consumer_read_data     (a_crd),
        .consumer_write_valid   (c_wv),
        .consumer_write_address (c_waddr),
        .consumer_write_data    (c_wdata),
        .consumer_write_ready   (a_cwr),
        .mem_read_valid         (a_mrv),
        .mem_read_address       (a_mra),
        .mem_read_ready         (a_mrr),
        .mem_read_data          (a_mrd),
        .mem_write_valid        (a_mwv),
        .mem_write_address      (a_mwa),
        .mem_write_data         (a_mwd),
        .mem_write_ready        (a_mwr),
        .timeout_flag           (a_tf)
    );

    mem_controller_rr #(.NUM_CHANNELS(1)) dut_b (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (c_rv),
        .consumer_read_address  (c_raddr),
        .consumer_read_ready    (b_crr),
        .consumer_read_data     (b_crd),
        .consumer_write_valid   (c_wv),
        .consumer_write_address (c_waddr),
        .consumer_write_data    (c_wdata),
        .consumer_write_ready   (b_cwr),
        .mem_read_valid         (b_mrv),
        .mem_read_address       (b_mra),
        .mem_read_ready         (b_mrr),
        .mem_read_data          (b_mrd),
        .mem_write_valid        (b_mwv),
        .mem_write_address      (b_mwa),
        .mem_write_data         (b_mwd),
        .mem_write_ready        (b_mwr),
        .timeout_flag           (b_tf)
    );

    // One vector is one clock edge on dut_a. The expected fields are the
    // outputs seen just after that edge.
    typedef struct packed {
        logic [3:0]  rv;
        logic [7:0]  addr0;
        logic [1:0]  mrr;
        logic [15:0] mrd0;
        logic [1:0]  exp_mrv;
        logic [7:0]  exp_mra0;
        logic [3:0]  exp_crr;
        logic [15:0] exp_crd0;
    } vec_t;

    vec_t vecs [10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        c_rv    = '0;
        c_wv    = '0;
        c_raddr = '0;
        c_waddr = '0;
        c_wdata = '0;
        a_mrr   = '0;
        a_mrd   = '0;
        a_mwr   = '0;
        b_mrr   = 1'b0;
        b_mrd   = '0;
        b_mwr   = 1'b0;
        repeat (3) step();
        reset = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        c_rv         = v.rv;
        c_raddr[7:0] = v.addr0;
        a_mrr        = v.mrr;
        a_mrd[15:0]  = v.mrd0;
        step();
    endtask

    task automatic check_output(input vec_t v, input int i);
        check($sformatf("vec%0d_mem_read_valid", i), 64'(a_mrv), 64'(v.exp_mrv));
        check($sformatf("vec%0d_mem_read_addr0", i), 64'(a_mra[7:0]), 64'(v.exp_mra0));
        check($sformatf("vec%0d_read_ready", i), 64'(a_crr), 64'(v.exp_crr));
        check($sformatf("vec%0d_read_data0", i), 64'(a_crd[15:0]), 64'(v.exp_crd0));
    endtask

    initial begin
        // Single read by consumer 0: grant, 3-cycle memory latency, relay,
        // release, then a re-request that rotates back to consumer 0.
        vecs[0] = '{4'b0001, 8'h10, 2'b00, 16'h0000, 2'b01, 8'h10, 4'b0000, 16'h0000};
        vecs[1] = '{4'b0001, 8'h10, 2'b00, 16'h0000, 2'b01, 8'h10, 4'b0000, 16'h0000};
        vecs[2] = '{4'b0001, 8'h10, 2'b00, 16'h0000, 2'b01, 8'h10, 4'b0000, 16'h0000};
        vecs[3] = '{4'b0001, 8'h10, 2'b01, 16'hABCD, 2'b00, 8'h10, 4'b0001, 16'hABCD};
        vecs[4] = '{4'b0001, 8'h10, 2'b00, 16'h0000, 2'b00, 8'h10, 4'b0001, 16'hABCD};
        vecs[5] = '{4'b0000, 8'h10, 2'b00, 16'h0000, 2'b00, 8'h10, 4'b0000, 16'hABCD};
        vecs[6] = '{4'b0000, 8'h10, 2'b00, 16'h0000, 2'b00, 8'h10, 4'b0000, 16'hABCD};
        vecs[7] = '{4'b0001, 8'h20, 2'b00, 16'h0000, 2'b01, 8'h20, 4'b0000, 16'hABCD};
        vecs[8] = '{4'b0001, 8'h20, 2'b01, 16'h5555, 2'b00, 8'h20, 4'b0001, 16'h5555};
        vecs[9] = '{4'b0000, 8'h20, 2'b00, 16'h0000, 2'b00, 8'h20, 4'b0000, 16'h5555};

        // Reset, then idle: every output of dut_a stays 0.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_ctrl", 64'({a_crr, a_cwr, a_mrv, a_mwv, a_tf}), 64'd0);
            check("idle_addr", {a_mra, a_mwa, a_mwd}, 64'd0);
            check("idle_rdata", a_crd, 64'd0);
        end

        // Table-driven single read.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i]);
            check_output(vecs[i], i);
        end

        // All four consumers read at once. The two channels serve c0/c1
        // first, then c2/c3.
        do_reset();
        c_rv    = 4'b1111;
        c_raddr = {8'h0C, 8'h08, 8'h04, 8'h00};
        step();
        check("all_first_valid", 64'(a_mrv), 64'(2'b11));
        check("all_first_addr", 64'(a_mra), 64'(16'h0400));
        a_mrr = 2'b11;
        a_mrd = {16'h3100, 16'h3000};
        step();
        check("all_first_ready", 64'(a_crr), 64'(4'b0011));
        check("all_first_valid_drop", 64'(a_mrv), 64'(2'b00));
        a_mrr = 2'b00;
        c_rv  = 4'b1100;
        step();
        check("all_first_release", 64'(a_crr), 64'(4'b0000));
        step();
        check("all_second_valid", 64'(a_mrv), 64'(2'b11));
        check("all_second_addr", 64'(a_mra), 64'(16'h0C08));
        a_mrr = 2'b11;
        a_mrd = {16'h3300, 16'h3200};
        step();
        check("all_second_ready", 64'(a_crr), 64'(4'b1100));
        a_mrr = 2'b00;
        c_rv  = 4'b0000;
        step();
        check("all_second_release", 64'(a_crr), 64'(4'b0000));
        check("all_read_data", a_crd, 64'h3300_3200_3100_3000);

        // Consumer 1 requests a read and a write together. The read goes
        // first, and the write follows once the read relay ends.
        do_reset();
        c_rv             = 4'b0010;
        c_wv             = 4'b0010;
        c_raddr[15:8]    = 8'h60;
        c_waddr[15:8]    = 8'h70;
        c_wdata[31:16]   = 16'h7777;
        step();
        check("rw_read_valid", 64'(a_mrv), 64'(2'b01));
        check("rw_read_addr", 64'(a_mra[7:0]), 64'h60);
        check("rw_no_write_yet", 64'(a_mwv), 64'd0);
        a_mrr       = 2'b01;
        a_mrd[15:0] = 16'h2222;
        step();
        check("rw_read_ready", 64'(a_crr), 64'(4'b0010));
        check("rw_read_data", 64'(a_crd[31:16]), 64'h2222);
        a_mrr = 2'b00;
        c_rv  = 4'b0000;
        step();
        check("rw_read_release", 64'(a_crr), 64'd0);
        check("rw_write_blocked", 64'(a_mwv), 64'd0);
        step();
        check("rw_write_valid", 64'(a_mwv), 64'(2'b01));
        check("rw_write_addr", 64'(a_mwa[7:0]), 64'h70);
        check("rw_write_data", 64'(a_mwd[15:0]), 64'h7777);
        a_mwr = 2'b01;
        step();
        check("rw_write_ready", 64'(a_cwr), 64'(4'b0010));
        check("rw_write_valid_drop", 64'(a_mwv), 64'd0);
        a_mwr = 2'b00;
        c_wv  = 4'b0000;
        step();
        check("rw_write_release", 64'(a_cwr), 64'd0);

        // Fairness on the single-channel instance: c3 wins before c0 gets
        // its second grant.
        do_reset();
        c_raddr = {8'h33, 8'h00, 8'h00, 8'h11};
        c_rv    = 4'b1001;
        step();
        check("fair_grant1", 64'({b_mrv, b_mra}), 64'({1'b1, 8'h11}));
        b_mrr = 1'b1;
        b_mrd = 16'h0A0A;
        step();
        check("fair_ready_c0", 64'(b_crr), 64'(4'b0001));
        b_mrr = 1'b0;
        c_rv  = 4'b1000;
        step();
        check("fair_release_c0", 64'(b_crr), 64'd0);
        c_rv = 4'b1001;
        step();
        check("fair_grant2_c3", 64'({b_mrv, b_mra}), 64'({1'b1, 8'h33}));
        b_mrr = 1'b1;
        b_mrd = 16'h0B0B;
        step();
        check("fair_ready_c3", 64'(b_crr), 64'(4'b1000));
        check("fair_data_c3", 64'(b_crd[63:48]), 64'h0B0B);
        b_mrr = 1'b0;
        c_rv  = 4'b0001;
        step();
        check("fair_release_c3", 64'(b_crr), 64'd0);
        step();
        check("fair_grant3_c0", 64'({b_mrv, b_mra}), 64'({1'b1, 8'h11}));

        // Cancellation: consumer 3 drops valid while ch0 waits. The response
        // is discarded, and ch0 is free again afterwards.
        do_reset();
        c_raddr[31:24] = 8'hB0;
        c_rv           = 4'b1000;
        step();
        check("cancel_grant", 64'({a_mrv, a_mra[7:0]}), 64'({2'b01, 8'hB0}));
        c_rv = 4'b0000;
        step();
        check("cancel_still_waiting", 64'(a_mrv), 64'(2'b01));
        a_mrr       = 2'b01;
        a_mrd[15:0] = 16'h1234;
        step();
        check("cancel_valid_drop", 64'(a_mrv), 64'd0);
        check("cancel_no_ready", 64'(a_crr), 64'd0);
        a_mrr = 2'b00;
        step();
        check("cancel_no_ready_late", 64'(a_crr), 64'd0);
        check("cancel_data_kept", a_crd, 64'd0);
        a_mrr        = 2'b10;
        a_mrd[31:16] = 16'hDEAD;
        step();
        check("stray_ready_ignored", 64'({a_crr, a_mrv}), 64'd0);
        check("stray_data_ignored", a_crd, 64'd0);
        a_mrr          = 2'b00;
        c_raddr[23:16] = 8'hC0;
        c_rv           = 4'b0100;
        step();
        check("cancel_ch0_idle", 64'({a_mrv, a_mra[7:0]}), 64'({2'b01, 8'hC0}));

`ifdef MEM_TIMEOUT_EN
        // Timeout: memory never answers, so ready appears 64 cycles after
        // the grant, with all-ones data.
        begin
            int cycles;
            do_reset();
            c_raddr[7:0] = 8'h44;
            c_rv         = 4'b0001;
            step();
            cycles = 0;
            while (!a_crr[0] && cycles < 200) begin
                step();
                cycles++;
            end
            check("timeout_latency", 64'(cycles), 64'd64);
            check("timeout_data", 64'(a_crd[15:0]), 64'hFFFF);
            check("timeout_flag", 64'(a_tf), 64'(2'b01));
            check("timeout_valid_drop", 64'(a_mrv), 64'd0);
            a_mrr       = 2'b01;
            a_mrd[15:0] = 16'h9999;
            step();
            check("timeout_late_ready", 64'(a_crd[15:0]), 64'hFFFF);
            a_mrr = 2'b00;
            c_rv  = 4'b0000;
            step();
            check("timeout_release", 64'({a_crr, a_tf}), 64'({4'b0000, 2'b01}));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
